gpu_textram: RTL and testbench
==============================

Name: gpu_textram

Overview:
- Parametrised text-mode VRAM for the Zucker GPU.
- CPU side: word-addressed, byte-strobed port with a valid/ready handshake.
- Display side: character-indexed read port with hardware vertical scroll (row-offset wrap-around).
- Built-in fill engine clears or paints the whole screen one word per clock, stalling the CPU port meanwhile.
- Sits between the SoC bus decoder and the character generator / video timing block.

Parameters:
- COLS, 80, characters per row
- ROWS, 25, rows per screen
- DATA_W, 32, CPU word width in bits; multiple of 8
- CHAR_W, 8, character cell width in bits; fixed at 8 in this generation
- Derived (localparam, not overridable):
  - BPW = DATA_W/8
  - TOTAL = COLS*ROWS
  - WORDS = TOTAL/BPW; TOTAL must be divisible by BPW
  - AW = $clog2(WORDS)
  - CW = $clog2(TOTAL)
  - RW = $clog2(ROWS)

Ports:
- clk  in  1  single system clock; every register is on its rising edge
- rst  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU request; held high until cpu_ready
- cpu_ready  out  1  one-cycle acknowledge
- cpu_addr  in  AW  word address
- cpu_wstrb  in  BPW  byte write strobes; all zero = read
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- disp_addr  in  CW  logical character index (row*COLS+col)
- disp_char  out  CHAR_W  character at disp_addr, two cycles later
- scroll_row  in  RW  first logical row maps to this physical row
- fill_start  in  1  pulse: begin whole-screen fill
- fill_char  in  CHAR_W  fill value, sampled on the accepting edge
- fill_busy  out  1  high while the fill engine owns the write port

Behaviour:
- Reset values:
  - cpu_ready=0, cpu_rdata=0, disp_char=0, fill_busy=0, state=IDLE.
  - Display pipeline registers are cleared.
  - RAM contents are not reset.
- Char-to-RAM mapping:
  - Char i lives in word i/BPW, lane i%BPW.
  - Lane 0 = bits 7:0 (little-endian).
- Control FSM states: IDLE, ACK, FILL.
  - IDLE, fill_start=1: latch fill_char, clear fill counter, go to FILL. fill_start wins over a simultaneous cpu_valid; that request stays pending.
  - IDLE, cpu_valid=1 (no fill_start): perform the access this edge, go to ACK.
    - Read-before-write: cpu_rdata gets the pre-write word.
    - Each set wstrb lane is written.
  - ACK: cpu_ready=1 for exactly this cycle; cpu_valid is ignored; next state IDLE.
    - Latency is request edge -> ready one cycle later.
    - Peak throughput is one transaction per 2 cycles.
  - FILL:
    - Each cycle, write the replicated fill_char to word fill_cnt (all lanes), then increment.
    - After word WORDS-1 is written, go to IDLE. FILL lasts exactly WORDS cycles.
    - fill_busy=1 for the whole FILL state and 0 otherwise.
    - fill_start during FILL is ignored.
    - cpu_ready stays 0 during FILL (CPU stalls).
- Out-of-range CPU address (cpu_addr >= WORDS): write discarded, cpu_rdata=0, handshake completes normally.
- cpu_rdata holds its value until the next accepted transaction.
- Display pipeline (free-running, never stalls):
  - Stage 1 registers the physical index p = disp_addr + scroll_row*COLS; if p >= TOTAL, p -= TOTAL.
    - scroll_row >= ROWS is treated as 0.
    - disp_addr >= TOTAL marks the entry invalid.
  - Stage 2 registers the RAM word at p/BPW and the lane p%BPW.
  - disp_char is the selected lane from the stage-2 registers, or 0 if the entry is invalid.
  - Latency: disp_addr at edge N -> disp_char valid after edge N+2.
- Simultaneous events:
  - A display read of a word written on the same edge returns the old data.
  - Display reads during FILL see partially filled contents; this is permitted.
- Reset mid-operation:
  - Mid-FILL: returns to IDLE with fill_busy=0 the next cycle; the RAM stays partially filled.
  - In ACK: the pending ready is dropped.
- RAM must infer as block RAM: one write/read port (CPU/fill) and one read port (display). No reset on the array.

Decomposition:
- Package gpu_pkg holds:
  - the FSM state encoding (IDLE/ACK/FILL);
  - CHAR_W;
  - default COLS/ROWS.
- One natural sub-module, gpu_textram_mem:
  - Plain dual-port RAM, WORDS x DATA_W.
  - Port A: byte-strobed write with read-before-write.
  - Port B: registered read.
  - The parent holds the FSM, fill counter and scroll arithmetic.

Test Plan:
- Reset, then idle -> cpu_ready=0, fill_busy=0, disp_char=0.
- Write addr 0, wstrb=1111, data 0x44434241; read addr 0 -> cpu_ready exactly one cycle after each request; read returns 0x44434241. disp_addr 0..3 -> 0x41,0x42,0x43,0x44 two cycles later.
- Partial write to addr 0, wstrb=0010, data 0x0000FF00 -> rdata of that write = 0x44434241; subsequent read = 0x4443FF41.
- fill_start with fill_char=0x20, cpu_valid asserted in the same cycle:
  - fill_busy high for exactly 500 cycles (defaults).
  - cpu_ready low throughout; the CPU access completes right after the fill.
  - Every word reads 0x20202020.
- scroll_row=1, write 'Z' at char 80 (word 20, lane 0):
  - disp_addr 0 -> 'Z'.
  - Wrap check: with scroll_row=24, disp_addr 80 -> char 0.
- Out-of-range and reset:
  - cpu_addr 500 write+read -> handshake completes, rdata=0, no RAM change.
  - disp_addr 2000 -> 0.
  - rst asserted at fill cycle 100 -> fill_busy=0 next cycle; words >= 100 keep their old contents.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the Zucker GPU text-mode VRAM: FSM encoding,
// character cell width and default screen geometry.
package gpu_pkg;

  localparam int CHAR_W   = 8;
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    FILL = 2'd2
  } state_e;

endpackage

// File: rtl/gpu_textram_mem.sv
// Dual-port word RAM: port A byte-strobed write with read-before-write and an
// enabled output register, port B free-running registered read.
module gpu_textram_mem #(
  parameter int WORDS  = 500,
  parameter int DATA_W = 32,
  parameter int AW     = 9,
  localparam int BPW   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              a_en_i,
  input  logic [BPW-1:0]    a_we_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [AW-1:0]     b_addr_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  // port A: old word is captured before the strobed lanes are overwritten
  always_ff @(posedge clk) begin
    if (a_en_i) begin
      a_rdata_o <= mem_q[a_addr_i];
    end
    for (int b = 0; b < BPW; b++) begin
      if (a_we_i[b]) begin
        mem_q[a_addr_i][b*8 +: 8] <= a_wdata_i[b*8 +: 8];
      end
    end
  end

  // port B: display read
  always_ff @(posedge clk) begin
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/gpu_textram.sv
// Text-mode VRAM: CPU word port with valid/ready, whole-screen fill engine and
// a two-stage display read pipeline with vertical scroll.
module gpu_textram
  import gpu_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = 32,
  parameter int CHAR_W = gpu_pkg::CHAR_W,
  localparam int BPW   = DATA_W / 8,
  localparam int TOTAL = COLS * ROWS,
  localparam int WORDS = TOTAL / BPW,
  localparam int AW    = $clog2(WORDS),
  localparam int CW    = $clog2(TOTAL),
  localparam int RW    = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [BPW-1:0]    cpu_wstrb,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [CW-1:0]     disp_addr,
  output logic [CHAR_W-1:0] disp_char,
  input  logic [RW-1:0]     scroll_row,
  input  logic              fill_start,
  input  logic [CHAR_W-1:0] fill_char,
  output logic              fill_busy
);

  localparam int LW = (BPW > 1) ? $clog2(BPW) : 1;

  state_e            state_q;
  logic [AW-1:0]     fill_cnt_q;
  logic [CHAR_W-1:0] fill_char_q;
  logic              cpu_ready_q;
  logic              fill_busy_q;
  logic              rzero_q;

  logic              in_range_s;
  logic              accept_s;
  logic              a_en_s;
  logic [BPW-1:0]    a_we_s;
  logic [AW-1:0]     a_addr_s;
  logic [DATA_W-1:0] a_wdata_s;
  logic [DATA_W-1:0] a_rdata_s;

  logic [RW-1:0]     scroll_s;
  logic [CW:0]       sum_s;
  logic [CW-1:0]     phys_s;
  logic              disp_ok_s;
  logic [CW-1:0]     p1_q;
  logic              v1_q;
  logic [LW-1:0]     lane2_q;
  logic              v2_q;
  logic [AW-1:0]     b_addr_s;
  logic [DATA_W-1:0] b_rdata_s;

  assign in_range_s = (32'(cpu_addr) < 32'(WORDS));
  assign accept_s   = (state_q == IDLE) && cpu_valid && !fill_start && !rst;

  // port A owner: fill engine in FILL, otherwise an accepted in-range CPU access
  always_comb begin
    a_en_s    = 1'b0;
    a_we_s    = '0;
    a_addr_s  = cpu_addr;
    a_wdata_s = cpu_wdata;
    if ((state_q == FILL) && !rst) begin
      a_we_s    = '1;
      a_addr_s  = fill_cnt_q;
      a_wdata_s = {BPW{fill_char_q}};
    end else if (accept_s && in_range_s) begin
      a_en_s = 1'b1;
      a_we_s = cpu_wstrb;
    end else begin
      a_en_s = 1'b0;
    end
  end

  // control FSM; fill_start has priority over a waiting CPU request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      fill_char_q <= '0;
      cpu_ready_q <= 1'b0;
      fill_busy_q <= 1'b0;
      rzero_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            fill_char_q <= fill_char;
            fill_cnt_q  <= '0;
            fill_busy_q <= 1'b1;
            state_q     <= FILL;
          end else if (cpu_valid) begin
            cpu_ready_q <= 1'b1;
            rzero_q     <= !in_range_s;
            state_q     <= ACK;
          end
        end
        ACK: begin
          cpu_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
        FILL: begin
          if (fill_cnt_q == AW'(WORDS - 1)) begin
            fill_busy_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            fill_cnt_q <= fill_cnt_q + AW'(1);
          end
        end
        default: begin
          cpu_ready_q <= 1'b0;
          fill_busy_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign fill_busy = fill_busy_q;
  // port A output register is only loaded by in-range CPU accesses
  assign cpu_rdata = rzero_q ? '0 : a_rdata_s;

  // logical -> physical character index with row-offset wrap
  always_comb begin
    if (32'(scroll_row) < 32'(ROWS)) begin
      scroll_s = scroll_row;
    end else begin
      scroll_s = '0;
    end
    sum_s = (CW+1)'(disp_addr) + (CW+1)'(32'(scroll_s) * 32'(COLS));
    if (32'(disp_addr) < 32'(TOTAL)) begin
      disp_ok_s = 1'b1;
      if (32'(sum_s) >= 32'(TOTAL)) begin
        phys_s = CW'(32'(sum_s) - 32'(TOTAL));
      end else begin
        phys_s = CW'(sum_s);
      end
    end else begin
      disp_ok_s = 1'b0;
      phys_s    = '0;
    end
  end

  // display pipeline stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q    <= '0;
      v1_q    <= 1'b0;
      lane2_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      p1_q    <= phys_s;
      v1_q    <= disp_ok_s;
      lane2_q <= LW'(p1_q % CW'(BPW));
      v2_q    <= v1_q;
    end
  end

  assign b_addr_s  = AW'(p1_q / CW'(BPW));
  assign disp_char = v2_q ? CHAR_W'(b_rdata_s >> {lane2_q, 3'b000}) : '0;

  gpu_textram_mem #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk       (clk),
    .a_en_i    (a_en_s),
    .a_we_i    (a_we_s),
    .a_addr_i  (a_addr_s),
    .a_wdata_i (a_wdata_s),
    .a_rdata_o (a_rdata_s),
    .b_addr_i  (b_addr_s),
    .b_rdata_o (b_rdata_s)
  );

endmodule

// File: tb/tb_gpu_textram.sv
// Scoreboard bench for gpu_textram at default geometry (80x25, 32-bit words).
module tb_gpu_textram;

  localparam int WORDS = 500;
  localparam int AW    = 9;
  localparam int CW    = 11;
  localparam int RW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_wstrb;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic [CW-1:0] disp_addr;
  logic [7:0]    disp_char;
  logic [RW-1:0] scroll_row;
  logic          fill_start;
  logic [7:0]    fill_char;
  logic          fill_busy;

  gpu_textram dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .disp_addr  (disp_addr),
    .disp_char  (disp_char),
    .scroll_row (scroll_row),
    .fill_start (fill_start),
    .fill_char  (fill_char),
    .fill_busy  (fill_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [31:0] data; bit dc; } cpu_exp_t;
  typedef struct { int due; logic [7:0] data; } disp_exp_t;
  cpu_exp_t  cpu_q[$];
  disp_exp_t disp_q[$];
  cpu_exp_t  ce;
  disp_exp_t de;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops expectations when the DUT presents a response
  always @(negedge clk) begin
    if (cpu_ready) begin
      if (cpu_q.size() == 0) begin
        chk("unexpected_ready", 32'(cpu_ready), 32'd0);
      end else begin
        ce = cpu_q.pop_front();
        if (!ce.dc) chk("cpu_rdata", cpu_rdata, ce.data);
      end
    end
    if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
      de = disp_q.pop_front();
      chk("disp_char", 32'(disp_char), 32'(de.data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xfer(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d,
                          input logic [31:0] exp, input bit dc = 1'b0);
    int n = 0;
    cpu_q.push_back('{exp, dc});
    cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = s; cpu_wdata = d;
    do begin step(); n++; end while (!cpu_ready && n < 20);
    chk("cpu_latency", 32'(n), 32'd1);
    cpu_valid = 1'b0; cpu_wstrb = 4'd0;
    step();
    chk("cpu_ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic disp_chk(input int a, input logic [7:0] exp);
    disp_addr = CW'(a);
    disp_q.push_back('{cyc + 2, exp});
    step();
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  initial begin
    int n;
    int m;
    int bad;
    rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = 4'd0; cpu_wdata = 32'd0;
    disp_addr = '0; scroll_row = '0; fill_start = 1'b0; fill_char = 8'd0;
    repeat (3) step();
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_disp", 32'(disp_char), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(cpu_ready), 32'd0);
    chk("idle_busy", 32'(fill_busy), 32'd0);

    // full write, read back, display lanes
    cpu_xfer(9'd0, 4'b1111, 32'h44434241, 32'd0, 1'b1);
    cpu_xfer(9'd0, 4'b0000, 32'd0, 32'h44434241);
    disp_chk(0, 8'h41); disp_chk(1, 8'h42); disp_chk(2, 8'h43); disp_chk(3, 8'h44);
    drain();

    // partial write with read-before-write
    cpu_xfer(9'd0, 4'b0010, 32'h0000FF00, 32'h44434241);
    cpu_xfer(9'd0, 4'b0000, 32'd0, 32'h4443FF41);
    disp_chk(1, 8'hFF);
    drain();

    // last word and out-of-range handling
    cpu_xfer(9'd499, 4'b1111, 32'h11223344, 32'd0, 1'b1);
    cpu_xfer(9'd499, 4'b0000, 32'd0, 32'h11223344);
    disp_chk(1996, 8'h44); disp_chk(1999, 8'h11);
    disp_chk(2000, 8'h00); disp_chk(2047, 8'h00);
    drain();
    cpu_xfer(9'd500, 4'b1111, 32'hDEADBEEF, 32'd0);
    cpu_xfer(9'd511, 4'b1111, 32'hCAFEF00D, 32'd0);
    cpu_xfer(9'd500, 4'b0000, 32'd0, 32'd0);
    cpu_xfer(9'd499, 4'b0000, 32'd0, 32'h11223344);
    cpu_xfer(9'd0, 4'b0000, 32'd0, 32'h4443FF41);

    // fill with a CPU read pending in the same cycle
    fill_start = 1'b1; fill_char = 8'h20;
    cpu_valid = 1'b1; cpu_addr = 9'd0; cpu_wstrb = 4'd0;
    cpu_q.push_back('{32'h20202020, 1'b0});
    step();
    fill_start = 1'b0; fill_char = 8'h55;
    n = 0; bad = 0;
    while (fill_busy && n < 1000) begin
      n++;
      if (cpu_ready) bad++;
      if (n == 10) begin fill_start = 1'b1; fill_char = 8'h66; end
      else fill_start = 1'b0;
      step();
    end
    fill_start = 1'b0;
    chk("fill_len", 32'(n), 32'd500);
    chk("fill_ready_low", 32'(bad), 32'd0);
    chk("rdata_hold", cpu_rdata, 32'h4443FF41);
    m = 0;
    do begin step(); m++; end while (!cpu_ready && m < 20);
    chk("post_fill_latency", 32'(m), 32'd1);
    cpu_valid = 1'b0;
    step();
    for (int w = 0; w < WORDS; w++) cpu_xfer(AW'(w), 4'b0000, 32'd0, 32'h20202020);

    // vertical scroll
    cpu_xfer(9'd20, 4'b0001, 32'h0000005A, 32'h20202020);
    cpu_xfer(9'd0, 4'b0001, 32'h00000030, 32'h20202020);
    scroll_row = 5'd1;
    disp_chk(0, 8'h5A); disp_chk(1, 8'h20); disp_chk(1920, 8'h30);
    drain();
    scroll_row = 5'd24;
    disp_chk(80, 8'h30); disp_chk(0, 8'h20);
    drain();
    scroll_row = 5'd25;
    disp_chk(80, 8'h5A); disp_chk(0, 8'h30);
    drain();
    scroll_row = 5'd31;
    disp_chk(80, 8'h5A);
    drain();
    scroll_row = 5'd0;

    // reset in the middle of a fill
    fill_start = 1'b1; fill_char = 8'h77;
    step();
    fill_start = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    chk("rst_fill_busy", 32'(fill_busy), 32'd0);
    chk("rst_fill_ready", 32'(cpu_ready), 32'd0);
    chk("rst_fill_disp", 32'(disp_char), 32'd0);
    rst = 1'b0;
    step();
    cpu_xfer(9'd0, 4'b0000, 32'd0, 32'h77777777);
    cpu_xfer(9'd20, 4'b0000, 32'd0, 32'h77777777);
    cpu_xfer(9'd99, 4'b0000, 32'd0, 32'h77777777);
    cpu_xfer(9'd100, 4'b0000, 32'd0, 32'h20202020);
    cpu_xfer(9'd499, 4'b0000, 32'd0, 32'h20202020);
    disp_chk(399, 8'h77); disp_chk(400, 8'h20);
    drain();

    chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("disp_q_empty", 32'(disp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
